// File: rtl/pipe_reg_chain_if.sv
// Bundle between hazard/branch control (master) and the pipeline register chain (slave).
// stall_cnt is only live when the chain is built with PIPE_STALL_CNT_EN.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             stall;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic [OCC_W-1:0] occupancy;
    logic [15:0]      stall_cnt;

    modport master (
        output stall, flush, in_valid, d,
        input  q, out_valid, occupancy, stall_cnt
    );

    modport slave (
        input  stall, flush, in_valid, d,
        output q, out_valid, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage data+valid pipeline register with stall and flush.
// Priority on each edge: reset > flush > stall > shift.
// Optional macro PIPE_STALL_CNT_EN builds a saturating count of stalled cycles
// that held live data; without it stall_cnt is tied to zero.
module pipe_reg_chain #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    pipe_reg_chain_if.slave    bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [OCC_W-1:0] occ;

    // Stage registers: clear on reset/flush, hold on stall, otherwise shift toward the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) data_r[i] <= RESET_VAL;
            valid_r <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) data_r[i] <= RESET_VAL;
            valid_r <= '0;
        end else if (!bus.stall) begin
            data_r[0]  <= bus.d;
            valid_r[0] <= bus.in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_r[i]  <= data_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    // Popcount of the valid bits; width covers 0..DEPTH so it cannot wrap.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(valid_r[i]);
    end

    assign bus.q         = data_r[DEPTH-1];
    assign bus.out_valid = valid_r[DEPTH-1];
    assign bus.occupancy = occ;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Count stalls that actually held data; flush does not clear it, only reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (bus.stall && !bus.flush && (occ != '0) && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
`else
    assign bus.stall_cnt = 16'h0000;
`endif
endmodule
